// File: rtl/obstacle_scheduler.sv
// Obstacle pool sequencer: per-frame scroll pulse bursts and LFSR-driven lane spawns.
// Optional spawn-period jitter is enabled by defining OBSTACLE_SCHED_JITTER_EN.
module obstacle_scheduler #(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned SPAWN_PERIOD = 90,
    parameter logic [7:0]  LANE_BASE    = 8'd40,
    parameter logic [7:0]  LANE_PITCH   = 8'd32,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic                 run,
    input  logic                 frame_tick,
    input  logic [2:0]           speed,
    input  logic [NUM_SLOTS-1:0] slot_on,
    output logic [NUM_SLOTS-1:0] slot_init,
    output logic [7:0]           spawn_x,
    output logic                 up_tick,
    output logic [7:0]           spawn_miss
);

    localparam logic [7:0] THR_BASE = 8'(SPAWN_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW}    scroll_e;
    typedef enum logic [1:0] {P_IDLE, P_FIRE, P_SETTLE} spawn_e;

    scroll_e                scroll_q, scroll_d;
    spawn_e                 spawn_q, spawn_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic [7:0]             frame_q, frame_d;
    logic                   pending_q, pending_d;
    logic [NUM_SLOTS-1:0]   sel_q, sel_d;
    logic [7:0]             spawn_x_q, spawn_x_d;
    logic [7:0]             miss_q, miss_d;

    logic                   frame_adv;
    logic                   wrap;
    logic [7:0]             thr;
    logic [NUM_SLOTS-1:0]   free_oh;
    logic                   found;
    logic [7:0]             lane_off;
    logic [7:0]             cand_x;

    assign frame_adv = frame_tick & run;
    assign wrap      = frame_adv && (frame_q == thr);

`ifdef OBSTACLE_SCHED_JITTER_EN
    logic [7:0] thr_q;
    logic [8:0] thr_sum;

    assign thr     = thr_q;
    assign thr_sum = {1'b0, THR_BASE} + {6'b0, lfsr_q[7:5]};

    // Threshold re-rolled from the LFSR at each wrap, saturating at 255.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n)   thr_q <= THR_BASE;
        else if (wrap) thr_q <= thr_sum[8] ? 8'hFF : thr_sum[7:0];
    end
`else
    assign thr = THR_BASE;
`endif

    always_comb begin
        free_oh = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_on[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign lane_off = {6'b0, lfsr_q[1:0]} * LANE_PITCH;
    assign cand_x   = LANE_BASE + lane_off;

    always_comb begin
        scroll_d = scroll_q;
        cnt_d    = cnt_q;
        up_tick  = 1'b0;
        if (!run) begin
            scroll_d = S_IDLE;
        end else begin
            case (scroll_q)
                S_IDLE: if (frame_tick && speed != 3'd0) begin
                    cnt_d    = speed;
                    scroll_d = S_HIGH;
                end
                S_HIGH: begin
                    up_tick  = 1'b1;
                    cnt_d    = cnt_q - 3'd1;
                    scroll_d = S_LOW;
                end
                S_LOW:   scroll_d = (cnt_q != 3'd0) ? S_HIGH : S_IDLE;
                default: scroll_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        spawn_d   = spawn_q;
        sel_d     = sel_q;
        spawn_x_d = spawn_x_q;
        miss_d    = miss_q;
        slot_init = '0;
        lfsr_d    = lfsr_q;
        frame_d   = frame_q;
        pending_d = pending_q;

        if (run) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (spawn_q)
            P_IDLE: if (frame_adv && pending_q) begin
                if (found) begin
                    sel_d     = free_oh;
                    spawn_x_d = cand_x;
                    spawn_d   = P_FIRE;
                end else if (miss_q != 8'hFF) begin
                    miss_d = miss_q + 8'd1;
                end
            end
            P_FIRE: begin
                slot_init = sel_q;
                pending_d = 1'b0;
                spawn_d   = P_SETTLE;
            end
            P_SETTLE: spawn_d = P_IDLE;
            default:  spawn_d = P_IDLE;
        endcase

        // A wrap landing on the fire cycle re-arms pending rather than being lost.
        if (frame_adv) begin
            if (wrap) begin
                frame_d   = '0;
                pending_d = 1'b1;
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            scroll_q  <= S_IDLE;
            spawn_q   <= P_IDLE;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            frame_q   <= '0;
            pending_q <= 1'b0;
            sel_q     <= '0;
            spawn_x_q <= LANE_BASE;
            miss_q    <= '0;
        end else begin
            scroll_q  <= scroll_d;
            spawn_q   <= spawn_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            spawn_x_q <= spawn_x_d;
            miss_q    <= miss_d;
        end
    end

    assign spawn_x    = spawn_x_q;
    assign spawn_miss = miss_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: expected pulses are queued by stimulus, popped by a monitor.
module tb_obstacle_scheduler;

    logic       clk = 1'b0;
    logic       init_n;
    logic       run;
    logic       frame_tick;
    logic [2:0] speed;
    logic [3:0] slot_on;
    logic [3:0] slot_init;
    logic [7:0] spawn_x;
    logic       up_tick;
    logic [7:0] spawn_miss;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  oh;
        logic [7:0]  x;
    } spawn_exp_t;

    int unsigned up_q[$];
    spawn_exp_t  sp_q[$];
    logic [7:0]  m_lfsr;

    obstacle_scheduler #(
        .NUM_SLOTS   (4),
        .SPAWN_PERIOD(2),
        .LANE_BASE   (8'd40),
        .LANE_PITCH  (8'd32),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clk       (clk),
        .init_n    (init_n),
        .run       (run),
        .frame_tick(frame_tick),
        .speed     (speed),
        .slot_on   (slot_on),
        .slot_init (slot_init),
        .spawn_x   (spawn_x),
        .up_tick   (up_tick),
        .spawn_miss(spawn_miss)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, steps while run is high.
    always @(posedge clk or negedge init_n) begin
        if (!init_n)  m_lfsr <= 8'hA5;
        else if (run) m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (up_tick === 1'b1) begin
            if (up_q.size() == 0) check("up_tick_unexpected", 32'd1, 32'd0);
            else check("up_tick_cycle", cyc, up_q.pop_front());
        end
        if (slot_init !== 4'b0000) begin
            if (sp_q.size() == 0) begin
                check("slot_init_unexpected", {28'd0, slot_init}, 32'd0);
            end else begin
                spawn_exp_t e;
                e = sp_q.pop_front();
                check("slot_init_cycle", cyc, e.cyc);
                check("slot_init_onehot", {28'd0, slot_init}, {28'd0, e.oh});
                check("spawn_x", {24'd0, spawn_x}, {24'd0, e.x});
            end
        end
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tick();
        @(posedge clk); #2 frame_tick = 1'b1;
        @(posedge clk); #2 frame_tick = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic tick_up(input int unsigned pulses);
        @(posedge clk); #2 frame_tick = 1'b1;
        for (int unsigned k = 1; k <= pulses; k++) up_q.push_back(cyc + 2 * k - 1);
        @(posedge clk); #2 frame_tick = 1'b0;
    endtask

    task automatic tick_spawn(input logic [3:0] oh);
        spawn_exp_t e;
        logic [7:0] l;
        @(posedge clk); #2 frame_tick = 1'b1;
        l    = m_lfsr;
        e.cyc = cyc + 1;
        e.oh  = oh;
        e.x   = 8'd40 + {6'b0, l[1:0]} * 8'd32;
        sp_q.push_back(e);
        @(posedge clk); #2 frame_tick = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        init_n = 1'b0; run = 1'b0; frame_tick = 1'b0; speed = 3'd0; slot_on = 4'b1111;
        wait_cycles(3);
        check("rst_slot_init", {28'd0, slot_init}, 32'd0);
        check("rst_up_tick", {31'd0, up_tick}, 32'd0);
        check("rst_spawn_x", {24'd0, spawn_x}, 32'd40);
        check("rst_spawn_miss", {24'd0, spawn_miss}, 32'd0);
        init_n = 1'b1;
        wait_cycles(2);
        run = 1'b1;

        // speed 3: pulses on cycles 1,3,5 after the tick
        speed = 3'd3;
        tick_up(3);
        wait_cycles(8);

        // speed 5 with run dropped 4 cycles after the tick: only 2 pulses
        speed = 3'd5;
        tick_up(2);
        wait_cycles(3);
        run = 1'b0;
        wait_cycles(6);
        run = 1'b1;
        speed = 3'd0;
        wait_cycles(2);

        // pending is set; all slots busy -> three misses
        repeat (3) tick();
        check("spawn_miss_3", {24'd0, spawn_miss}, 32'd3);
        slot_on = 4'b0111;
        tick_spawn(4'b1000);
        wait_cycles(2);

        // pending cleared: two ticks to re-arm, third spawns lowest free slot
        slot_on = 4'b0101;
        tick();
        tick();
        tick_spawn(4'b0010);
        wait_cycles(2);

        // saturation of the miss counter
        slot_on = 4'b1111;
        tick();
        tick();
        repeat (250) tick();
        check("spawn_miss_254", {24'd0, spawn_miss}, 32'd254);
        tick();
        check("spawn_miss_255", {24'd0, spawn_miss}, 32'd255);
        repeat (5) tick();
        check("spawn_miss_sat", {24'd0, spawn_miss}, 32'd255);

        // reset while both a scroll pulse and an init pulse are high
        slot_on = 4'b1110;
        speed = 3'd2;
        @(posedge clk); #2 frame_tick = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_up_tick", {31'd0, up_tick}, 32'd1);
        check("pre_rst_slot_init", {28'd0, slot_init}, 32'd1);
        #1 frame_tick = 1'b0;
        init_n = 1'b0;
        #1;
        check("mid_rst_up_tick", {31'd0, up_tick}, 32'd0);
        check("mid_rst_slot_init", {28'd0, slot_init}, 32'd0);
        check("mid_rst_spawn_x", {24'd0, spawn_x}, 32'd40);
        check("mid_rst_spawn_miss", {24'd0, spawn_miss}, 32'd0);
        speed = 3'd0;
        wait_cycles(3);
        init_n = 1'b1;
        wait_cycles(6);

        // after release a full spawn period is needed before the next spawn
        tick();
        tick();
        tick_spawn(4'b0001);
        wait_cycles(8);

        check("up_q_leftover", up_q.size(), 32'd0);
        check("spawn_q_leftover", sp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
